// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter: one multiply-by-10-and-add per digit, MSD first,
// with valid/ready on both sides. Optional build macro: BCD_SATURATE_EN (clamp on overflow).
module bcd_to_binary #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      binary,
  output logic                  overflow,
  output logic                  invalid
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int ACC_W = 4 * DIGITS;
  localparam int EXT_W = ACC_W + BIN_W;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_e;

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   bcd_sr_q, bcd_sr_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               inv_q, inv_d;
  logic [BIN_W-1:0]   binary_q, binary_d;
  logic               overflow_q, overflow_d;
  logic               invalid_q, invalid_d;

  logic [3:0]         digit;
  logic [ACC_W-1:0]   acc_step;
  logic               inv_step;
  logic [EXT_W-1:0]   acc_ext;
  logic               acc_over;
  logic               last_digit;

  // Out-of-range digits are still accumulated; the sticky flag masks the result later.
  assign digit      = bcd_sr_q[BCD_W-1 -: 4];
  assign acc_step   = (acc_q << 3) + (acc_q << 1) + ACC_W'(digit);
  assign inv_step   = inv_q | (digit > 4'd9);
  assign acc_ext    = EXT_W'(acc_step);
  assign acc_over   = (acc_ext >> BIN_W) != '0;
  assign last_digit = (cnt_q == CNT_W'(DIGITS - 1));

  // NOTE: every always_comb output gets its default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    bcd_sr_d   = bcd_sr_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    inv_d      = inv_q;
    binary_d   = binary_q;
    overflow_d = overflow_q;
    invalid_d  = invalid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bcd_sr_d = bcd;
          acc_d    = '0;
          inv_d    = 1'b0;
          cnt_d    = '0;
          state_d  = CONVERT;
        end
      end
      CONVERT: begin
        acc_d    = acc_step;
        inv_d    = inv_step;
        bcd_sr_d = bcd_sr_q << 4;
        if (last_digit) begin
          state_d = DONE;
          if (inv_step) begin
            binary_d   = '0;
            overflow_d = 1'b0;
            invalid_d  = 1'b1;
          end else if (acc_over) begin
            overflow_d = 1'b1;
            invalid_d  = 1'b0;
`ifdef BCD_SATURATE_EN
            binary_d   = '1;
`else
            binary_d   = acc_ext[BIN_W-1:0];
`endif
          end else begin
            binary_d   = acc_ext[BIN_W-1:0];
            overflow_d = 1'b0;
            invalid_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bcd_sr_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      inv_q      <= 1'b0;
      binary_q   <= '0;
      overflow_q <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcd_sr_q   <= bcd_sr_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      inv_q      <= inv_d;
      binary_q   <= binary_d;
      overflow_q <= overflow_d;
      invalid_q  <= invalid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign binary    = binary_q;
  assign overflow  = overflow_q;
  assign invalid   = invalid_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed self-checking bench for bcd_to_binary (DIGITS=3, BIN_W=8); honours BCD_SATURATE_EN.
module tb_bcd_to_binary;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] bcd;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  binary;
  logic        overflow;
  logic        invalid;

  int checks;
  int errors;

  bcd_to_binary #(.DIGITS(3), .BIN_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd       (bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .binary    (binary),
    .overflow  (overflow),
    .invalid   (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one word, waits for the result, checks latency and outputs, then accepts it.
  task automatic convert(input logic [11:0] word, input logic [7:0] exp_bin,
                         input logic exp_ovf, input logic exp_inv, input string tag);
    int lat;
    int wait_cnt;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 20) begin
      tick();
      wait_cnt++;
    end
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    bcd      = word;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'd3);
    check({tag, ".binary"},  32'(binary),   32'(exp_bin));
    check({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
    check({tag, ".invalid"},  32'(invalid),  32'(exp_inv));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".out_valid_clr"}, 32'(out_valid), 32'd0);
    check({tag, ".in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] ovf256;
    logic [7:0] ovf999;
    logic [11:0] w;
    int lat;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bcd       = '0;
`ifdef BCD_SATURATE_EN
    ovf256 = 8'hFF;
    ovf999 = 8'hFF;
`else
    ovf256 = 8'h00;
    ovf999 = 8'hE7;
`endif
    tick();
    tick();
    reset = 1'b0;
    check("rst.in_ready",  32'(in_ready),  32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.binary",    32'(binary),    32'd0);
    check("rst.overflow",  32'(overflow),  32'd0);
    check("rst.invalid",   32'(invalid),   32'd0);

    convert(12'h089, 8'h59, 1'b0, 1'b0, "w089");
    convert(12'h255, 8'hFF, 1'b0, 1'b0, "w255");
    convert(12'h256, ovf256, 1'b1, 1'b0, "w256");
    convert(12'h999, ovf999, 1'b1, 1'b0, "w999");
    convert(12'h0A5, 8'h00, 1'b0, 1'b1, "w0A5");
    convert(12'h042, 8'h2A, 1'b0, 1'b0, "w042");

    // Backpressure: result held, new words ignored while DONE.
    in_valid = 1'b1;
    bcd      = 12'h123;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("bp.latency", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      bcd      = 12'h456;
      tick();
      in_valid = 1'b0;
      check("bp.out_valid", 32'(out_valid), 32'd1);
      check("bp.binary",    32'(binary),    32'h7B);
      check("bp.overflow",  32'(overflow),  32'd0);
      check("bp.invalid",   32'(invalid),   32'd0);
      check("bp.in_ready",  32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp.out_valid_clr", 32'(out_valid), 32'd0);
    check("bp.in_ready_back", 32'(in_ready),  32'd1);
    for (int i = 0; i < 4; i++) tick();
    check("bp.no_ghost", 32'(out_valid), 32'd0);

    // Reset one cycle into CONVERT aborts the word.
    in_valid = 1'b1;
    bcd      = 12'h089;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort.in_ready",  32'(in_ready),  32'd1);
    check("abort.out_valid", 32'(out_valid), 32'd0);
    check("abort.binary",    32'(binary),    32'd0);
    for (int i = 0; i < 5; i++) tick();
    check("abort.no_result", 32'(out_valid), 32'd0);

    // Sweep every in-range value 0..255.
    for (int v = 0; v < 256; v++) begin
      w = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      convert(w, 8'(v), 1'b0, 1'b0, $sformatf("sweep%0d", v));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
